// File: rtl/ufm_dump_pkg.sv
// ufm_dump_pkg: shared definitions for the UFM dump sequencer.
//   state_t       - sequencer state encoding (IDLE / RUN / BREAK, 2 bits)
//   ms_to_cycles  - converts a pause in milliseconds to clock cycles
//   last_addr     - last byte address of a window of 16-byte UFM pages
package ufm_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  // Integer division first so the product stays inside 32 bits for
  // realistic clock rates.
  function automatic logic [31:0] ms_to_cycles(input logic [31:0] clk_hz,
                                               input logic [31:0] break_ms);
    ms_to_cycles = (clk_hz / 32'd1000) * break_ms;
  endfunction

  function automatic logic [31:0] last_addr(input logic [31:0] num_pages);
    last_addr = (num_pages * 32'd16) - 32'd1;
  endfunction

endpackage

// File: rtl/ufm_dump_seq_interval_timer.sv
// interval_timer: loadable down-counter used to time the pause between passes.
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   load     in   load load_val into the counter
//   load_val in   WIDTH-bit reload value
//   clear    in   force the counter to zero (wins over load)
//   expired  out  counter is at zero
module interval_timer
  import ufm_dump_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;

  // Down-counter: clear, then load, then count towards zero and hold there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/ufm_dump_seq.sv
// ufm_dump_seq: walks a byte address across NUM_PAGES 16-byte UFM pages and
// gates reads from page_buffer towards a byte sink (uart), in one-shot or
// loop mode with a millisecond pause between passes.
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   start       in   pulse, begins a pass when idle
//   oneshot     in   level, sampled at pass end (1 = stop, 0 = loop)
//   abort       in   pulse, return to idle (highest priority)
//   byte_valid  in   page_buffer has the byte at byte_addr ready
//   sink_ready  in   uart transmitter empty
//   read_en     out  page_buffer read enable (combinational)
//   byte_addr   out  page_buffer byte address
//   busy        out  registered, high in RUN or BREAK
//   pass_done   out  registered one-cycle pulse when a pass completes
//   pass_count  out  completed passes, wrapping
module ufm_dump_seq
  import ufm_dump_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int ADDR_W    = 15,
  parameter int CLK_HZ    = 24180000,
  parameter int BREAK_MS  = 500,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              oneshot,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic              sink_ready,
  output logic              read_en,
  output logic [ADDR_W-1:0] byte_addr,
  output logic              busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  pass_count
);

  localparam logic [31:0] BREAK_CYC  = ms_to_cycles(32'(CLK_HZ), 32'(BREAK_MS));
  localparam logic [31:0] LAST_FULL  = last_addr(32'(NUM_PAGES));
  localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_FULL[ADDR_W-1:0];
  localparam logic        BREAK_EN   = (BREAK_CYC != 32'd0);
  // Loaded on the accepting cycle, so BREAK_CYC-1 more cycles plus the
  // expiry cycle give exactly BREAK_CYC cycles in BREAK.
  localparam logic [31:0] TIMER_LOAD = BREAK_EN ? (BREAK_CYC - 32'd1) : 32'd0;

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic [CNT_W-1:0]    count_r, count_next_s;
  logic                done_r, done_next_s;
  logic                busy_r;
  logic                accept_s;
  logic                timer_load_s, timer_clear_s, timer_expired_s;

  assign read_en  = (state_r == ST_RUN) && sink_ready;
  assign accept_s = read_en && byte_valid;

  interval_timer #(.WIDTH(32)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (TIMER_LOAD),
    .clear    (timer_clear_s),
    .expired  (timer_expired_s)
  );

  // Next-state, address, counter and pulse decode; abort overrides everything.
  always_comb begin
    state_next_s  = state_r;
    addr_next_s   = addr_r;
    count_next_s  = count_r;
    done_next_s   = 1'b0;
    timer_load_s  = 1'b0;
    timer_clear_s = 1'b0;
    if (abort) begin
      state_next_s  = ST_IDLE;
      addr_next_s   = {ADDR_W{1'b0}};
      timer_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_next_s = ST_RUN;
            addr_next_s  = {ADDR_W{1'b0}};
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (addr_r == LAST_ADDR) begin
              addr_next_s  = {ADDR_W{1'b0}};
              done_next_s  = 1'b1;
              count_next_s = count_r + CNT_W'(1);
              if (oneshot) begin
                state_next_s = ST_IDLE;
              end else if (!BREAK_EN) begin
                state_next_s = ST_RUN;
              end else begin
                state_next_s = ST_BREAK;
                timer_load_s = 1'b1;
              end
            end else begin
              addr_next_s = addr_r + ADDR_W'(1);
            end
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_BREAK: begin
          if (timer_expired_s) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_BREAK;
          end
        end
        default: begin
          state_next_s  = ST_IDLE;
          addr_next_s   = {ADDR_W{1'b0}};
          timer_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      addr_r  <= addr_next_s;
      count_r <= count_next_s;
      done_r  <= done_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
    end
  end

  assign byte_addr  = addr_r;
  assign pass_count = count_r;
  assign pass_done  = done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ufm_dump_seq.sv
// tb_ufm_dump_seq: self-checking bench for ufm_dump_seq. Two instances share
// all inputs: dut_a pauses 5 cycles between passes, dut_b has no pause.
// A pass-level behavioural model tracks both and is compared every cycle;
// a vector table and hand-written sequences pin down the corner cases.
module tb_ufm_dump_seq;

  localparam int AW = 8;
  localparam int CW = 16;
  localparam int LAST = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, oneshot = 1'b0, abort = 1'b0;
  logic byte_valid = 1'b1, sink_ready = 1'b1;

  logic          re_a, re_b, busy_a, busy_b, done_a, done_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ufm_dump_seq #(.NUM_PAGES(1), .ADDR_W(AW), .CLK_HZ(1000), .BREAK_MS(5), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .oneshot(oneshot), .abort(abort),
    .byte_valid(byte_valid), .sink_ready(sink_ready), .read_en(re_a),
    .byte_addr(addr_a), .busy(busy_a), .pass_done(done_a), .pass_count(cnt_a));

  ufm_dump_seq #(.NUM_PAGES(1), .ADDR_W(AW), .CLK_HZ(1000), .BREAK_MS(0), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .oneshot(oneshot), .abort(abort),
    .byte_valid(byte_valid), .sink_ready(sink_ready), .read_en(re_b),
    .byte_addr(addr_b), .busy(busy_b), .pass_done(done_b), .pass_count(cnt_b));

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = streaming bytes, 2 = pausing (pause = cycles left)
  typedef struct {
    int mode;
    int addr;
    int pause;
    int count;
    int done;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t mstep(mstate_t s, int pause_cycles, logic st, logic os,
                                    logic ab, logic sr, logic bv);
    mstate_t r;
    r = s;
    r.done = 0;
    if (ab) begin
      r.mode = 0; r.addr = 0; r.pause = 0;
    end else if (s.mode == 0) begin
      if (st) begin r.mode = 1; r.addr = 0; end
    end else if (s.mode == 1) begin
      if (sr && bv) begin
        if (s.addr == LAST) begin
          r.addr = 0;
          r.done = 1;
          r.count = (s.count + 1) % (1 << CW);
          if (os) r.mode = 0;
          else if (pause_cycles > 0) begin r.mode = 2; r.pause = pause_cycles; end
        end else begin
          r.addr = s.addr + 1;
        end
      end
    end else begin
      r.pause = s.pause - 1;
      if (r.pause == 0) r.mode = 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= '{0, 0, 0, 0, 0};
      mb <= '{0, 0, 0, 0, 0};
    end else begin
      ma <= mstep(ma, 5, start, oneshot, abort, sink_ready, byte_valid);
      mb <= mstep(mb, 0, start, oneshot, abort, sink_ready, byte_valid);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_a_read_en", {31'd0, re_a}, {31'd0, (ma.mode == 1) && sink_ready});
    chk("model_a_addr", {24'd0, addr_a}, ma.addr);
    chk("model_a_busy", {31'd0, busy_a}, {31'd0, ma.mode != 0});
    chk("model_a_done", {31'd0, done_a}, ma.done);
    chk("model_a_count", {16'd0, cnt_a}, ma.count);
    chk("model_b_read_en", {31'd0, re_b}, {31'd0, (mb.mode == 1) && sink_ready});
    chk("model_b_addr", {24'd0, addr_b}, mb.addr);
    chk("model_b_busy", {31'd0, busy_b}, {31'd0, mb.mode != 0});
    chk("model_b_done", {31'd0, done_b}, mb.done);
    chk("model_b_count", {16'd0, cnt_b}, mb.count);
  endtask

  // Drive one cycle's inputs at the falling edge, then compare against the model.
  task automatic cyc(input logic s, input logic os, input logic ab,
                     input logic sr, input logic bv);
    @(negedge clk);
    start = s; oneshot = os; abort = ab; sink_ready = sr; byte_valid = bv;
    #1;
    check_model();
  endtask

  typedef struct {
    logic st, os, ab, sr, bv;
    logic re;
    logic [AW-1:0] addr;
    logic busy, done;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // ---------------- reset state ----------------
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_read_en", {31'd0, re_a}, 32'd0);
    chk("rst_addr", {24'd0, addr_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_count", {16'd0, cnt_a}, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- vector table: start, backpressure, abort ----------------
    //           st    os    ab    sr    bv    re    addr   busy  done  cnt
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 16'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 16'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 16'd0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 16'd0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].st, tbl[i].os, tbl[i].ab, tbl[i].sr, tbl[i].bv);
      chk($sformatf("tbl%0d_read_en", i), {31'd0, re_a}, {31'd0, tbl[i].re});
      chk($sformatf("tbl%0d_addr", i), {24'd0, addr_a}, {24'd0, tbl[i].addr});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy_a}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_done", i), {31'd0, done_a}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_count", i), {16'd0, cnt_a}, {16'd0, tbl[i].cnt});
    end

    // ---------------- one-shot pass ----------------
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= LAST; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk($sformatf("os_addr%0d", i), {24'd0, addr_a}, i);
      chk($sformatf("os_re%0d", i), {31'd0, re_a}, 32'd1);
      chk($sformatf("os_done%0d", i), {31'd0, done_a}, 32'd0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("os_end_done", {31'd0, done_a}, 32'd1);
    chk("os_end_count", {16'd0, cnt_a}, 32'd1);
    chk("os_end_busy", {31'd0, busy_a}, 32'd0);
    chk("os_end_re", {31'd0, re_a}, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("os_after_done", {31'd0, done_a}, 32'd0);
    chk("os_after_re", {31'd0, re_a}, 32'd0);

    // ---------------- loop mode with 5-cycle break ----------------
    @(negedge clk); #1; rst = 1'b0; #3; rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i <= LAST; i++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk($sformatf("loop%0d_addr%0d", p, i), {24'd0, addr_a}, i);
        chk($sformatf("loop%0d_re%0d", p, i), {31'd0, re_a}, 32'd1);
      end
      if (p < 2) begin
        for (int k = 0; k < 5; k++) begin
          cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
          chk($sformatf("brk%0d_re%0d", p, k), {31'd0, re_a}, 32'd0);
          chk($sformatf("brk%0d_busy%0d", p, k), {31'd0, busy_a}, 32'd1);
          chk($sformatf("brk%0d_done%0d", p, k), {31'd0, done_a}, (k == 0) ? 32'd1 : 32'd0);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("loop_count3", {16'd0, cnt_a}, 32'd3);
    chk("loop_brk_re", {31'd0, re_a}, 32'd0);
    // abort during the pause
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abrt_brk_busy_before", {31'd0, busy_a}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("abrt_brk_busy", {31'd0, busy_a}, 32'd0);
    chk("abrt_brk_addr", {24'd0, addr_a}, 32'd0);
    chk("abrt_brk_count", {16'd0, cnt_a}, 32'd3);

    // ---------------- abort at addr 9 coincident with accept ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abrt9_addr_before", {24'd0, addr_a}, 32'd9);
    chk("abrt9_re_before", {31'd0, re_a}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("abrt9_addr", {24'd0, addr_a}, 32'd0);
    chk("abrt9_busy", {31'd0, busy_a}, 32'd0);
    chk("abrt9_done", {31'd0, done_a}, 32'd0);
    chk("abrt9_count", {16'd0, cnt_a}, 32'd3);

    // ---------------- asynchronous reset mid-pass at addr 7 ----------------
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mrst_addr_before", {24'd0, addr_a}, 32'd7);
    rst = 1'b0;
    #1;
    chk("mrst_addr", {24'd0, addr_a}, 32'd0);
    chk("mrst_re", {31'd0, re_a}, 32'd0);
    chk("mrst_busy", {31'd0, busy_a}, 32'd0);
    chk("mrst_done", {31'd0, done_a}, 32'd0);
    chk("mrst_count", {16'd0, cnt_a}, 32'd0);
    #2 rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mrst_restart_addr", {24'd0, addr_a}, 32'd0);
    chk("mrst_restart_re", {31'd0, re_a}, 32'd1);

    // ---------------- zero pause loop on dut_b, start while busy ----------------
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= LAST; i++) begin
      cyc((i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("nb_addr%0d", i), {24'd0, addr_b}, i);
      chk($sformatf("nb_re%0d", i), {31'd0, re_b}, 32'd1);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("nb_wrap_addr", {24'd0, addr_b}, 32'd0);
    chk("nb_wrap_re", {31'd0, re_b}, 32'd1);
    chk("nb_wrap_done", {31'd0, done_b}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("nb_next_addr", {24'd0, addr_b}, 32'd1);
    chk("nb_next_done", {31'd0, done_b}, 32'd0);

    // ---------------- randomized traffic against the model ----------------
    begin
      logic os_lvl;
      os_lvl = 1'b0;
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 19) == 0) os_lvl = ~os_lvl;
        cyc(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            os_lvl,
            ($urandom_range(0, 47) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
